// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Command-driven controller for an up/down counter. Commands (LOAD,
//   COUNT_UP, COUNT_DOWN, SEEK) arrive on a valid/ready port, are queued in a
//   small FIFO and executed one at a time. SEEK watches the counter output
//   and finishes on a match or after 2^WIDTH cycles (timeout, flagged by err).
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready = FIFO not full)
//   cmd_op, cmd_arg     : opcode (00 LOAD, 01 UP, 10 DOWN, 11 SEEK) and argument
//   abort               : synchronous flush of FIFO and active command
//   cnt_data_in, cnt_load, cnt_enable, cnt_up_down : counter control outputs
//   cnt_data_out        : counter value fed back
//   busy                : FSM active or FIFO non-empty
//   done, err           : completion pulse, timeout pulse (with done)
//   fifo_count          : number of queued commands
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_arg,
  input  logic                     abort,
  output logic [WIDTH-1:0]         cnt_data_in,
  output logic                     cnt_load,
  output logic                     cnt_enable,
  output logic                     cnt_up_down,
  input  logic [WIDTH-1:0]         cnt_data_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_SEEK = 2'd3
  } state_t;

  // FIFO storage and pointers
  logic [1:0]       op_mem_q  [DEPTH];
  logic [WIDTH-1:0] arg_mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // FSM and command datapath
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] tmo_q, tmo_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             push_s;
  logic             pop_s;
  logic             match_s;
  logic [1:0]       head_op_s;
  logic [WIDTH-1:0] head_arg_s;

  // No bypass: ready depends only on the registered occupancy.
  assign cmd_ready  = (count_q < CW'(DEPTH));
  assign push_s     = cmd_valid & cmd_ready & ~abort;
  assign pop_s      = (state_q == S_IDLE) & (count_q != {CW{1'b0}}) & ~abort;
  assign head_op_s  = op_mem_q[rd_ptr_q];
  assign head_arg_s = arg_mem_q[rd_ptr_q];
  assign match_s    = (cnt_data_out == arg_q);

  assign busy       = (state_q != S_IDLE) | (count_q != {CW{1'b0}});
  assign done       = done_q;
  assign err        = err_q;
  assign fifo_count = count_q;

  // FIFO payload write (storage needs no reset; occupancy is tracked by count_q)
  always_ff @(posedge clk) begin
    if (push_s) begin
      op_mem_q[wr_ptr_q]  <= cmd_op;
      arg_mem_q[wr_ptr_q] <= cmd_arg;
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register: FSM, command datapath and FIFO control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      arg_q    <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      tmo_q    <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic: pop/dispatch, run countdown, seek match/timeout
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (abort) begin
      // Aborted commands never report completion.
      state_d = S_IDLE;
      rem_d   = {WIDTH{1'b0}};
      tmo_d   = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            op_d  = head_op_s;
            arg_d = head_arg_s;
            rem_d = head_arg_s;
            tmo_d = {WIDTH{1'b0}};
            case (head_op_s)
              OP_LOAD: state_d = S_LOAD;
              OP_UP, OP_DOWN: begin
                // A zero-length run completes straight from the pop.
                if (head_arg_s == {WIDTH{1'b0}}) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end else begin
                  state_d = S_RUN;
                end
              end
              OP_SEEK: state_d = S_SEEK;
              default: state_d = S_IDLE;
            endcase
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        S_RUN: begin
          rem_d = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
        S_SEEK: begin
          if (match_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (tmo_q == {WIDTH{1'b1}}) begin
            // This is the 2^WIDTH-th SEEK cycle without a match.
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_SEEK;
            tmo_d   = tmo_q + WIDTH'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: counter controls decoded from the current state
  always_comb begin
    cnt_data_in = {WIDTH{1'b0}};
    cnt_load    = 1'b0;
    cnt_enable  = 1'b0;
    cnt_up_down = 1'b0;
    case (state_q)
      S_LOAD: begin
        cnt_load    = 1'b1;
        cnt_data_in = arg_q;
      end
      S_RUN: begin
        cnt_enable  = 1'b1;
        cnt_up_down = (op_q == OP_UP);
      end
      S_SEEK: begin
        // Enable drops combinationally in the cycle the counter matches.
        cnt_up_down = 1'b1;
        cnt_enable  = ~match_s;
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;
  logic [7:0] cnt_data_in;
  logic       cnt_load;
  logic       cnt_enable;
  logic       cnt_up_down;
  logic [7:0] cnt_data_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] fifo_count;

  // environment counter
  logic       cnt_rst;
  logic [7:0] cnt_q;

  int total = 0;
  int bad   = 0;

  // observation counters
  int up_en, dn_en, ld_cnt, done_cnt, err_cnt;
  int last_din, last_err;

  // behavioural model
  int mq_op[$];
  int mq_arg[$];
  bit m_active;
  int m_op, m_arg, m_left, m_seek;
  bit m_done, m_err;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort),
    .cnt_data_in(cnt_data_in), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .cnt_up_down(cnt_up_down), .cnt_data_out(cnt_data_out),
    .busy(busy), .done(done), .err(err), .fifo_count(fifo_count)
  );

  // simple up/down counter driven by the sequencer
  always @(posedge clk) begin
    if (cnt_rst) cnt_q <= 8'd0;
    else if (cnt_load) cnt_q <= cnt_data_in;
    else if (cnt_enable) cnt_q <= cnt_up_down ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end
  assign cnt_data_out = cnt_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare + model step, once per cycle at the falling edge
  initial begin
    bit e_load, e_en, e_ud, push_ok, nd, ne;
    int e_din;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq_op.delete(); mq_arg.delete();
        m_active = 1'b0; m_done = 1'b0; m_err = 1'b0;
      end
      e_load = 1'b0; e_en = 1'b0; e_ud = 1'b0; e_din = 0;
      if (m_active) begin
        case (m_op)
          0: begin e_load = 1'b1; e_din = m_arg; end
          1: begin e_en = 1'b1; e_ud = 1'b1; end
          2: begin e_en = 1'b1; e_ud = 1'b0; end
          default: begin e_ud = 1'b1; e_en = (int'(cnt_data_out) != m_arg); end
        endcase
      end
      chk("cnt_load", 32'(cnt_load), 32'(e_load));
      chk("cnt_enable", 32'(cnt_enable), 32'(e_en));
      if (!m_active || m_op == 0) chk("cnt_data_in", 32'(cnt_data_in), e_din);
      if (!m_active || m_op != 0) chk("cnt_up_down", 32'(cnt_up_down), 32'(e_ud));
      chk("cmd_ready", 32'(cmd_ready), 32'(mq_op.size() < DEPTH));
      chk("fifo_count", 32'(fifo_count), mq_op.size());
      chk("busy", 32'(busy), 32'(m_active || mq_op.size() > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));

      if (cnt_enable && cnt_up_down) up_en++;
      if (cnt_enable && !cnt_up_down) dn_en++;
      if (cnt_load) begin ld_cnt++; last_din = int'(cnt_data_in); end
      if (done) begin done_cnt++; last_err = int'(err); if (err) err_cnt++; end

      if (!reset) begin
        push_ok = cmd_valid && (mq_op.size() < DEPTH);
        if (abort) begin
          mq_op.delete(); mq_arg.delete();
          m_active = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else begin
          nd = 1'b0; ne = 1'b0;
          if (m_active) begin
            case (m_op)
              0: begin m_active = 1'b0; nd = 1'b1; end
              1, 2: begin
                m_left--;
                if (m_left == 0) begin m_active = 1'b0; nd = 1'b1; end
              end
              default: begin
                m_seek++;
                if (int'(cnt_data_out) == m_arg) begin
                  m_active = 1'b0; nd = 1'b1;
                end else if (m_seek == (1 << WIDTH)) begin
                  m_active = 1'b0; nd = 1'b1; ne = 1'b1;
                end
              end
            endcase
          end else if (mq_op.size() > 0) begin
            m_op  = mq_op.pop_front();
            m_arg = mq_arg.pop_front();
            if ((m_op == 1 || m_op == 2) && m_arg == 0) nd = 1'b1;
            else begin m_active = 1'b1; m_left = m_arg; m_seek = 0; end
          end
          if (push_ok) begin
            mq_op.push_back(int'(cmd_op));
            mq_arg.push_back(int'(cmd_arg));
          end
          m_done = nd; m_err = ne;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_obs();
    up_en = 0; dn_en = 0; ld_cnt = 0; done_cnt = 0; err_cnt = 0;
    last_din = -1; last_err = -1;
  endtask

  task automatic push(input int op, input int arg);
    int n;
    n = 0;
    cmd_op = op[1:0]; cmd_arg = arg[7:0]; cmd_valid = 1'b1;
    while (!cmd_ready && n < 3000) begin tick(1); n++; end
    if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 32'd1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy || done) && n < limit) begin tick(1); n++; end
    if (busy || done) chk("wait_idle_timeout", 32'(busy | done), 32'd0);
  endtask

  initial begin
    int op, arg;
    reset = 1'b1; cnt_rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_arg = 8'd0; abort = 1'b0;
    clr_obs();
    tick(3);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0; cnt_rst = 1'b0;
    tick(1);

    // single LOAD
    clr_obs();
    push(0, 8'h2A);
    wait_idle(50);
    chk("t1_load_cycles", ld_cnt, 32'd1);
    chk("t1_din", last_din, 32'h2A);
    chk("t1_data_out", 32'(cnt_data_out), 32'h2A);
    chk("t1_done", done_cnt, 32'd1);

    // LOAD 10, UP 5, DOWN 3
    clr_obs();
    push(0, 10); push(1, 5); push(2, 3);
    wait_idle(100);
    chk("t2_up_cycles", up_en, 32'd5);
    chk("t2_down_cycles", dn_en, 32'd3);
    chk("t2_data_out", 32'(cnt_data_out), 32'd12);
    chk("t2_done", done_cnt, 32'd3);
    chk("t2_busy", 32'(busy), 32'd0);

    // FIFO full while busy
    clr_obs();
    push(1, 20);
    push(0, 1); push(1, 2); push(2, 1); push(1, 3);
    chk("t3_fifo_count", 32'(fifo_count), 32'd4);
    chk("t3_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t3_model_q", mq_op.size(), 32'd4);
    push(0, 7);
    wait_idle(200);
    chk("t3_data_out", 32'(cnt_data_out), 32'd7);
    chk("t3_done", done_cnt, 32'd6);

    // SEEK with wrap-around
    clr_obs();
    push(0, 8'hF0); push(3, 8'h05);
    wait_idle(400);
    chk("t4_enable_cycles", up_en, 32'd21);
    chk("t4_data_out", 32'(cnt_data_out), 32'h05);
    chk("t4_err", last_err, 32'd0);
    chk("t4_done", done_cnt, 32'd2);

    // SEEK timeout with counter held in reset
    clr_obs();
    cnt_rst = 1'b1;
    push(3, 8'h80);
    wait_idle(1000);
    chk("t5_seek_cycles", up_en, 32'd256);
    chk("t5_err", last_err, 32'd1);
    chk("t5_done", done_cnt, 32'd1);
    chk("t5_err_cnt", err_cnt, 32'd1);
    cnt_rst = 1'b0;
    tick(1);

    // abort mid-run, with a same-cycle push that must be dropped
    push(0, 0); push(1, 200); push(1, 5); push(0, 3);
    tick(20);
    clr_obs();
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 8'h99;
    tick(1);
    abort = 1'b0; cmd_valid = 1'b0;
    chk("t6_enable", 32'(cnt_enable), 32'd0);
    chk("t6_fifo_count", 32'(fifo_count), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    tick(5);
    chk("t6_no_done", done_cnt, 32'd0);
    push(0, 8'h33);
    wait_idle(50);
    chk("t6_data_out", 32'(cnt_data_out), 32'h33);
    chk("t6_done", done_cnt, 32'd1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      if (op == 1 || op == 2) arg = int'($urandom_range(0, 6));
      else arg = int'($urandom_range(0, 255));
      push(op, arg);
      tick(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 15) == 0) begin abort = 1'b1; tick(1); abort = 1'b0; end
      if ($urandom_range(0, 15) == 0) begin cnt_rst = 1'b1; tick(2); cnt_rst = 1'b0; end
    end
    wait_idle(3000);

    // asynchronous reset in the middle of a command
    push(1, 50); push(0, 8'h11);
    tick(10);
    #2 reset = 1'b1;
    #1;
    chk("t7_enable", 32'(cnt_enable), 32'd0);
    chk("t7_fifo_count", 32'(fifo_count), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    clr_obs();
    push(0, 8'h5A);
    wait_idle(50);
    chk("t7_data_out", 32'(cnt_data_out), 32'h5A);
    chk("t7_done", done_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
